// File: rtl/adder_pkg.sv
// Shared definitions for the adder result path: operand widths, collector
// state encoding and a constant clog2 used to size counters.
package adder_pkg;

    localparam int SUM_W = 4;
    localparam int RES_W = 5;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/adder_result_collector_if.sv
// Input (adder result) and output (batch result) handshakes of the collector.
// master = upstream/downstream environment, slave = the collector itself.
interface adder_result_collector_if
    import adder_pkg::*;
#(
    parameter int ACC_W = 8,
    parameter int CNT_W = 3
);

    logic             in_valid;
    logic             in_ready;
    logic [SUM_W-1:0] sum;
    logic             overflow;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] total;
    logic [CNT_W-1:0] ovf_count;

    modport master (
        output in_valid, sum, overflow, out_ready,
        input  in_ready, out_valid, total, ovf_count
    );

    modport slave (
        input  in_valid, sum, overflow, out_ready,
        output in_ready, out_valid, total, ovf_count
    );

endinterface

// File: rtl/acc_add.sv
// ACC_W-wide accumulator adder taking a zero-extended RES_W operand.
// Saturates at all-ones when ACC_SAT_EN is defined, otherwise wraps.
module acc_add
    import adder_pkg::*;
#(
    parameter int ACC_W = 8
) (
    input  logic [ACC_W-1:0] a,
    input  logic [RES_W-1:0] b,
    output logic [ACC_W-1:0] y
);

    logic [ACC_W:0] full;

    // One extra bit keeps the carry so saturation can be detected.
    assign full = {1'b0, a} + {{(ACC_W + 1 - RES_W){1'b0}}, b};

`ifdef ACC_SAT_EN
    assign y = full[ACC_W] ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
    assign y = full[ACC_W-1:0];
`endif

endmodule

// File: rtl/adder_result_collector.sv
// Sums BATCH adder results and counts carry-outs, then holds the batch result
// until taken. Optional saturating arithmetic via the ACC_SAT_EN macro.
module adder_result_collector
    import adder_pkg::*;
#(
    parameter int BATCH = 4,
    parameter int ACC_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    adder_result_collector_if.slave  bus
);

    localparam int CNT_W = clog2(BATCH + 1);

    state_t           state_reg, state_next;
    logic [ACC_W-1:0] acc_reg, acc_next;
    logic [ACC_W-1:0] total_reg, total_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] ovf_reg, ovf_next;
    logic [CNT_W-1:0] ovf_count_reg, ovf_count_next;
    logic [ACC_W-1:0] acc_sum;
    logic [CNT_W-1:0] ovf_sum;
    logic [RES_W-1:0] sample;

    assign sample  = {bus.overflow, bus.sum};
    assign ovf_sum = ovf_reg + CNT_W'(bus.overflow);

    // The same adder produces both the running sum and the final batch total.
    acc_add #(.ACC_W(ACC_W)) u_acc_add (
        .a(acc_reg),
        .b(sample),
        .y(acc_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ACCUM;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            ovf_reg       <= '0;
            total_reg     <= '0;
            ovf_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            cnt_reg       <= cnt_next;
            ovf_reg       <= ovf_next;
            total_reg     <= total_next;
            ovf_count_reg <= ovf_count_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        cnt_next       = cnt_reg;
        ovf_next       = ovf_reg;
        total_next     = total_reg;
        ovf_count_next = ovf_count_reg;

        case (state_reg)
            ACCUM: begin
                if (bus.in_valid) begin
                    if (cnt_reg == CNT_W'(BATCH - 1)) begin
                        total_next     = acc_sum;
                        ovf_count_next = ovf_sum;
                        acc_next       = '0;
                        ovf_next       = '0;
                        cnt_next       = '0;
                        state_next     = HOLD;
                    end else begin
                        acc_next = acc_sum;
                        ovf_next = ovf_sum;
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_next = ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase

        // Clear overrides everything, including a pending output handshake.
        if (clear) begin
            state_next     = ACCUM;
            acc_next       = '0;
            cnt_next       = '0;
            ovf_next       = '0;
            total_next     = '0;
            ovf_count_next = '0;
        end
    end

    assign bus.in_ready  = (state_reg == ACCUM);
    assign bus.out_valid = (state_reg == HOLD);
    assign bus.total     = total_reg;
    assign bus.ovf_count = ovf_count_reg;

endmodule

// File: tb/tb_adder_result_collector.sv
// Directed + randomized bench for adder_result_collector; an ACC_W=8 and an
// ACC_W=6 instance run in lockstep. Honors ACC_SAT_EN in its reference model.
module tb_adder_result_collector;
    import adder_pkg::*;

    localparam int BATCH = 4;
    localparam int CNT_W = clog2(BATCH + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic clear = 1'b0;

    always #5 clk = ~clk;

    adder_result_collector_if #(.ACC_W(8), .CNT_W(CNT_W)) bus ();
    adder_result_collector_if #(.ACC_W(6), .CNT_W(CNT_W)) bus6 ();

    assign bus6.in_valid  = bus.in_valid;
    assign bus6.sum       = bus.sum;
    assign bus6.overflow  = bus.overflow;
    assign bus6.out_ready = bus.out_ready;

    adder_result_collector #(.BATCH(BATCH), .ACC_W(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(clear),
        .bus  (bus)
    );

    adder_result_collector #(.BATCH(BATCH), .ACC_W(6)) dut6 (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(clear),
        .bus  (bus6)
    );

    int total_n = 0;
    int bad_n   = 0;
    int rises   = 0;
    int vals[BATCH];

    always @(posedge bus.out_valid) rises++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_n++;
        assert (obs === exp) else begin
            bad_n++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Reference: sum of the batch values, then modulo or clamp at the width.
    function automatic int model_total(input int width);
        int s;
        int lim;
        s   = 0;
        lim = (1 << width);
        foreach (vals[i]) s += vals[i];
`ifdef ACC_SAT_EN
        return (s > lim - 1) ? lim - 1 : s;
`else
        return s % lim;
`endif
    endfunction

    function automatic int model_ovf();
        int c;
        c = 0;
        foreach (vals[i]) if (vals[i] >= 16) c++;
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int v, input int gap);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.sum      = v[3:0];
        bus.overflow = v[4];
        while (!bus.in_ready && n < 50) begin
            step();
            n++;
        end
        check("push_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        bus.sum      = 4'($urandom);
        bus.overflow = 1'($urandom);
        repeat (gap) step();
    endtask

    task automatic fill_batch(input string tag, input int gap);
        for (int i = 0; i < BATCH; i++) push(vals[i], (i == BATCH - 1) ? 0 : gap);
        $display("batch %s: vals=%0d,%0d,%0d,%0d total=%0d/%0d ovf=%0d", tag,
                 vals[0], vals[1], vals[2], vals[3], bus.total, bus6.total, bus.ovf_count);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        check({tag, "_total8"}, 32'(bus.total), 32'(model_total(8)));
        check({tag, "_ovf8"}, 32'(bus.ovf_count), 32'(model_ovf()));
        check({tag, "_total6"}, 32'(bus6.total), 32'(model_total(6)));
        check({tag, "_ovf6"}, 32'(bus6.ovf_count), 32'(model_ovf()));
    endtask

    // Stall the output for hold cycles while upstream keeps offering data.
    task automatic pop(input string tag, input int hold);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.sum      = 4'($urandom);
            bus.overflow = 1'($urandom);
            step();
            check({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
            check({tag, "_hold_total"}, 32'(bus.total), 32'(model_total(8)));
            check({tag, "_hold_ovf"}, 32'(bus.ovf_count), 32'(model_ovf()));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check({tag, "_pop_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_pop_in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.sum       = '0;
        bus.overflow  = 1'b0;
        bus.out_ready = 1'b0;

        // Asynchronous reset before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_total", 32'(bus.total), 32'd0);
        check("rst_ovf", 32'(bus.ovf_count), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Basic batch 5+19+15+31, then 5 cycles of backpressure.
        vals = '{5, 19, 15, 31};
        fill_batch("basic", 0);
        check("basic_total70", 32'(bus.total), 32'd70);
        check("basic_ovf2", 32'(bus.ovf_count), 32'd2);
        pop("basic", 5);

        for (int b = 0; b < 8; b++) begin
            foreach (vals[i]) vals[i] = int'($urandom_range(0, 31));
            fill_batch("rand", int'($urandom_range(0, 2)));
            pop("rand", int'($urandom_range(0, 3)));
        end

        // Clear mid-batch with a sample offered in the same cycle.
        push(10, 0);
        push(10, 0);
        bus.in_valid = 1'b1;
        bus.sum      = 4'd7;
        bus.overflow = 1'b0;
        clear        = 1'b1;
        step();
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        check("clr_in_ready", 32'(bus.in_ready), 32'd1);
        vals = '{1, 1, 1, 1};
        fill_batch("clr", 0);
        check("clr_total4", 32'(bus.total), 32'd4);
        pop("clr", 0);

        // Clear together with out_ready in HOLD: batch dropped.
        vals = '{17, 20, 3, 9};
        fill_batch("clrhold", 1);
        clear         = 1'b1;
        bus.out_ready = 1'b1;
        step();
        clear         = 1'b0;
        bus.out_ready = 1'b0;
        check("clrhold_out_valid", 32'(bus.out_valid), 32'd0);
        check("clrhold_total", 32'(bus.total), 32'd0);
        check("clrhold_ovf", 32'(bus.ovf_count), 32'd0);
        check("clrhold_total6", 32'(bus6.total), 32'd0);

        // Four 31s: 124 fits in 8 bits, wraps or saturates in 6 bits.
        vals = '{31, 31, 31, 31};
        fill_batch("wrap", 0);
        check("wrap_total8", 32'(bus.total), 32'd124);
        check("wrap_ovf4", 32'(bus.ovf_count), 32'd4);
`ifdef ACC_SAT_EN
        check("wrap_total6", 32'(bus6.total), 32'd63);
`else
        check("wrap_total6", 32'(bus6.total), 32'd60);
`endif
        pop("wrap", 1);

        // Asynchronous reset while holding a result, between clock edges.
        vals = '{17, 2, 30, 4};
        fill_batch("arst", 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_total", 32'(bus.total), 32'd0);
        check("arst_ovf", 32'(bus.ovf_count), 32'd0);
        #2 rst_n = 1'b1;
        step();
        check("arst_in_ready", 32'(bus.in_ready), 32'd1);
        check("arst_out_valid_after", 32'(bus.out_valid), 32'd0);

        // Sparse input: idle gaps must not advance the count.
        rises = 0;
        vals  = '{3, 3, 3, 3};
        fill_batch("sparse", 2);
        check("sparse_total12", 32'(bus.total), 32'd12);
        pop("sparse", 0);
        repeat (4) step();
        check("sparse_rises", 32'(rises), 32'd1);

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
